// File: rtl/req_arbiter_32.sv
// req_arbiter_32: 32-requester arbiter with sticky pending bits, per-requester
// mask and fixed or rotating priority, presenting one grant at a time over a
// valid/ack handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : request pulses, each set bit latches into pending
//   mask_wr      : load mask from mask_data (1 = requester disabled)
//   grant_ack    : consumer accepts the presented grant
//   grant_valid  : a grant is being presented
//   grant_idx    : index of the granted requester
//   pending      : sticky pending bits
//   busy         : arbiter is in the GRANT state
module req_arbiter_32 #(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] req,
   input  logic        mask_wr,
   input  logic [31:0] mask_data,
   input  logic        grant_ack,
   output logic        grant_valid,
   output logic [4:0]  grant_idx,
   output logic [31:0] pending,
   output logic        busy
);

   localparam int unsigned N  = 32;
   localparam int unsigned IW = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_pending;
   logic [N-1:0]    r_mask;
   logic [N-1:0]    w_elig;
   logic [N-1:0]    w_clr;
   logic [N-1:0]    w_pending_nxt;
   logic [N-1:0]    w_mask_nxt;
   logic [IW-1:0]   r_grant_idx;
   logic [IW-1:0]   r_last;
   logic [IW-1:0]   w_sel_idx;
   logic [IW-1:0]   w_grant_idx_nxt;
   logic [IW-1:0]   w_last_nxt;
   logic            r_grant_valid;
   logic            w_grant_valid_nxt;
   logic            w_any_elig;

   assign w_elig     = r_pending & ~r_mask;
   assign w_any_elig = |w_elig;

   // Priority select; later loop iterations overwrite earlier ones, so the
   // last hit in each loop is the winner.
   always_comb begin : sel_p
      logic [IW-1:0] v_cand;
      w_sel_idx = '0;
      v_cand    = '0;
      if (ROUND_ROBIN) begin
         // Offsets 32..1 from last: offset 1 (last-1) wins, offset 32 is last itself.
         for (int j = 32; j >= 1; j--) begin
            v_cand = r_last - IW'(j);
            if (w_elig[v_cand]) w_sel_idx = v_cand;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (w_elig[i]) w_sel_idx = IW'(i);
         end
      end
   end

   // Next-state and registered-output values.
   always_comb begin
      w_state_nxt       = r_state;
      w_grant_valid_nxt = r_grant_valid;
      w_grant_idx_nxt   = r_grant_idx;
      w_last_nxt        = r_last;
      w_clr             = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_elig) begin
               w_state_nxt       = ST_GRANT;
               w_grant_valid_nxt = 1'b1;
               w_grant_idx_nxt   = w_sel_idx;
            end
         end
         ST_GRANT: begin
            if (grant_ack) begin
               w_state_nxt       = ST_IDLE;
               w_grant_valid_nxt = 1'b0;
               w_clr             = N'(1) << r_grant_idx;
               w_last_nxt        = r_grant_idx;
            end
         end
         default: begin
            w_state_nxt       = ST_IDLE;
            w_grant_valid_nxt = 1'b0;
         end
      endcase
   end

   // New requests are OR-ed in after the ack-clear so a same-cycle set wins.
   assign w_pending_nxt = (r_pending & ~w_clr) | req;
   assign w_mask_nxt    = mask_wr ? mask_data : r_mask;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_grant_valid <= 1'b0;
         r_grant_idx   <= '0;
         r_last        <= '0;
         r_pending     <= '0;
         r_mask        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_grant_idx   <= w_grant_idx_nxt;
         r_last        <= w_last_nxt;
         r_pending     <= w_pending_nxt;
         r_mask        <= w_mask_nxt;
      end
   end

   assign grant_valid = r_grant_valid;
   assign grant_idx   = r_grant_idx;
   assign pending     = r_pending;
   assign busy        = (r_state == ST_GRANT);

endmodule

// File: tb/tb_req_arbiter_32.sv
// tb_req_arbiter_32: directed bench for req_arbiter_32, one fixed-priority and
// one rotating-priority instance sharing the same stimulus.
module tb_req_arbiter_32;

   logic        clk;
   logic        rst_n;
   logic [31:0] req;
   logic        mask_wr;
   logic [31:0] mask_data;
   logic        grant_ack;

   logic        fp_valid;
   logic [4:0]  fp_idx;
   logic [31:0] fp_pend;
   logic        fp_busy;
   logic        rr_valid;
   logic [4:0]  rr_idx;
   logic [31:0] rr_pend;
   logic        rr_busy;

   int n_cmp;
   int n_fail;

   req_arbiter_32 #(.ROUND_ROBIN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req), .mask_wr(mask_wr),
      .mask_data(mask_data), .grant_ack(grant_ack),
      .grant_valid(fp_valid), .grant_idx(fp_idx), .pending(fp_pend), .busy(fp_busy)
   );

   req_arbiter_32 #(.ROUND_ROBIN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .mask_wr(mask_wr),
      .mask_data(mask_data), .grant_ack(grant_ack),
      .grant_valid(rr_valid), .grant_idx(rr_idx), .pending(rr_pend), .busy(rr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      mask_wr   = 1'b0;
      mask_data = '0;
      grant_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_idx !== 5'd0 || fp_pend !== 32'h0 || fp_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_fp: got v=%b i=%0d p=%h b=%b expected 0/0/0/0", fp_valid, fp_idx, fp_pend, fp_busy);
      end
      n_cmp++;
      if (rr_valid !== 1'b0 || rr_idx !== 5'd0 || rr_pend !== 32'h0 || rr_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rr: got v=%b i=%0d p=%h b=%b expected 0/0/0/0", rr_valid, rr_idx, rr_pend, rr_busy);
      end
   endtask

   task automatic test_fixed();
      logic [4:0] exp_seq [3];
      exp_seq[0] = 5'd15; exp_seq[1] = 5'd8; exp_seq[2] = 5'd0;
      do_reset();
      req = 32'h0000_8101;
      tick();
      req = '0;
      n_cmp++;
      if (fp_pend !== 32'h0000_8101 || fp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fixed_latch: got p=%h v=%b expected 00008101/0", fp_pend, fp_valid);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (fp_valid !== 1'b1 || fp_idx !== exp_seq[k] || fp_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_grant%0d: got v=%b i=%0d b=%b expected 1/%0d/1", k, fp_valid, fp_idx, fp_busy, exp_seq[k]);
         end
         grant_ack = 1'b1;
         tick();
         grant_ack = 1'b0;
         n_cmp++;
         if (fp_valid !== 1'b0 || fp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_ack%0d: got v=%b b=%b expected 0/0", k, fp_valid, fp_busy);
         end
      end
      n_cmp++;
      if (fp_pend !== 32'h0) begin
         n_fail++;
         $display("FAIL fixed_drain: got p=%h expected 00000000", fp_pend);
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] exp_seq [6];
      exp_seq[0] = 5'd31; exp_seq[1] = 5'd1; exp_seq[2] = 5'd0;
      exp_seq[3] = 5'd31; exp_seq[4] = 5'd1; exp_seq[5] = 5'd0;
      do_reset();
      req = 32'h8000_0003;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++;
         if (rr_valid !== 1'b1 || rr_idx !== exp_seq[k]) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got v=%b i=%0d expected 1/%0d", k, rr_valid, rr_idx, exp_seq[k]);
         end
         grant_ack = 1'b1;
         tick();
         grant_ack = 1'b0;
         n_cmp++;
         if (rr_valid !== 1'b0 || rr_pend !== 32'h8000_0003) begin
            n_fail++;
            $display("FAIL rr_ack%0d: got v=%b p=%h expected 0/80000003", k, rr_valid, rr_pend);
         end
      end
      req = '0;
   endtask

   task automatic test_mask();
      do_reset();
      mask_wr   = 1'b1;
      mask_data = 32'hFFFF_0000;
      tick();
      mask_wr = 1'b0;
      req     = (32'd1 << 20) | (32'd1 << 3);
      tick();
      req = '0;
      tick();
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd3 || fp_pend !== 32'h0010_0008) begin
         n_fail++;
         $display("FAIL mask_grant3: got v=%b i=%0d p=%h expected 1/3/00100008", fp_valid, fp_idx, fp_pend);
      end
      mask_wr   = 1'b1;
      mask_data = 32'h0;
      tick();
      mask_wr = 1'b0;
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd3) begin
         n_fail++;
         $display("FAIL mask_hold: got v=%b i=%0d expected 1/3", fp_valid, fp_idx);
      end
      grant_ack = 1'b1;
      tick();
      grant_ack = 1'b0;
      tick();
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd20) begin
         n_fail++;
         $display("FAIL mask_grant20: got v=%b i=%0d expected 1/20", fp_valid, fp_idx);
      end
      grant_ack = 1'b1;
      tick();
      grant_ack = 1'b0;
      // A mask write coinciding with an IDLE evaluation still sees the old mask.
      req = 32'd1 << 9;
      tick();
      req       = '0;
      mask_wr   = 1'b1;
      mask_data = 32'd1 << 9;
      tick();
      mask_wr = 1'b0;
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd9) begin
         n_fail++;
         $display("FAIL mask_old_same_cycle: got v=%b i=%0d expected 1/9", fp_valid, fp_idx);
      end
      grant_ack = 1'b1;
      tick();
      grant_ack = 1'b0;
      n_cmp++;
      if (fp_pend !== 32'h0 || fp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_drain: got p=%h v=%b expected 00000000/0", fp_pend, fp_valid);
      end
   endtask

   task automatic test_handshake_hold();
      do_reset();
      req = 32'd1 << 7;
      tick();
      req = '0;
      tick();
      for (int c = 0; c < 10; c++) begin
         req = (c == 3) ? (32'd1 << 30) : 32'h0;
         tick();
         n_cmp++;
         if (fp_valid !== 1'b1 || fp_idx !== 5'd7 || fp_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_c%0d: got v=%b i=%0d b=%b expected 1/7/1", c, fp_valid, fp_idx, fp_busy);
         end
      end
      req       = '0;
      grant_ack = 1'b1;
      tick();
      grant_ack = 1'b0;
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_pend !== (32'd1 << 30)) begin
         n_fail++;
         $display("FAIL hold_ack: got v=%b p=%h expected 0/40000000", fp_valid, fp_pend);
      end
      tick();
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd30) begin
         n_fail++;
         $display("FAIL hold_next30: got v=%b i=%0d expected 1/30", fp_valid, fp_idx);
      end
      grant_ack = 1'b1;
      tick();
      grant_ack = 1'b0;
   endtask

   task automatic test_ack_idle();
      do_reset();
      grant_ack = 1'b1;
      tick();
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_idle_quiet: got v=%b b=%b expected 0/0", fp_valid, fp_busy);
      end
      req = 32'd1 << 2;
      tick();
      req = '0;
      tick();
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd2 || fp_pend !== 32'h4) begin
         n_fail++;
         $display("FAIL ack_idle_ignored: got v=%b i=%0d p=%h expected 1/2/00000004", fp_valid, fp_idx, fp_pend);
      end
      tick();
      grant_ack = 1'b0;
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_pend !== 32'h0) begin
         n_fail++;
         $display("FAIL ack_idle_clear: got v=%b p=%h expected 0/00000000", fp_valid, fp_pend);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 32'h0000_0F00;
      tick();
      req = '0;
      tick();
      n_cmp++;
      if (fp_valid !== 1'b1 || fp_idx !== 5'd11 || fp_pend !== 32'h0000_0F00) begin
         n_fail++;
         $display("FAIL rstmid_pre: got v=%b i=%0d p=%h expected 1/11/00000F00", fp_valid, fp_idx, fp_pend);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_idx !== 5'd0 || fp_pend !== 32'h0 || fp_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got v=%b i=%0d p=%h b=%b expected 0/0/0/0", fp_valid, fp_idx, fp_pend, fp_busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      n_cmp++;
      if (fp_valid !== 1'b0 || fp_pend !== 32'h0 || rr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after: got v=%b p=%h rv=%b expected 0/00000000/0", fp_valid, fp_pend, rr_valid);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      req    = '0;
      mask_wr   = 1'b0;
      mask_data = '0;
      grant_ack = 1'b0;
      test_reset();
      test_fixed();
      test_round_robin();
      test_mask();
      test_handshake_hold();
      test_ack_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
